// File: rtl/riscv_loader_pkg.sv
// Shared types and defaults for the boot-time memory loader.
package riscv_loader_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DM_ADDRESS = 9;
  localparam int DEF_RESET_HOLD = 4;

  localparam logic TGT_INST = 1'b0;
  localparam logic TGT_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_LO = 3'd1,
    ST_GET_HI = 3'd2,
    ST_WRITE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  // A session may only be (re)started from a resting state.
  function automatic logic can_start(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/riscv_mem_loader_addr_ctr.sv
// Per-target pair address counter: saturates at all-ones and flags overflow
// once a write has consumed the last address.
module loader_addr_ctr #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] count,
  output logic          ovf
);

  // Counter advances after each write; the top address write sets ovf instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {AW{1'b0}};
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= {AW{1'b0}};
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == {AW{1'b1}}) begin
        ovf <= 1'b1;
      end else begin
        count <= count + AW'(1);
      end
    end else begin
      count <= count;
      ovf   <= ovf;
    end
  end

endmodule

// File: rtl/riscv_mem_loader.sv
// Boot loader: packs a 32-bit word stream into pairs, writes them through the
// core's ExMem port and holds the core in reset until loading has finished.
module riscv_mem_loader
  import riscv_loader_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DM_ADDRESS = DEF_DM_ADDRESS,
  parameter int RESET_HOLD = DEF_RESET_HOLD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_target,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_last,
  output logic                  enable_load_ex_mem,
  output logic [DM_ADDRESS-1:0] InstExMemAddress,
  output logic [DATA_W-1:0]     InstExMemData1,
  output logic [DATA_W-1:0]     InstExMemData2,
  output logic [DM_ADDRESS-1:0] DataExMemAddress,
  output logic [DATA_W-1:0]     DataExMemData1,
  output logic [DATA_W-1:0]     DataExMemData2,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  loader_state_t         state_r;
  logic                  pair_tgt_r;
  logic                  pair_last_r;
  logic [DATA_W-1:0]     lo_r;
  logic [HOLD_W-1:0]     hold_cnt_r;

  logic                  accept_s;
  logic                  start_ok_s;
  logic                  inst_inc_s;
  logic                  data_inc_s;
  logic [DM_ADDRESS-1:0] inst_cnt_s;
  logic [DM_ADDRESS-1:0] data_cnt_s;
  logic                  inst_ovf_s;
  logic                  data_ovf_s;
  logic                  lo_ovf_s;
  logic                  pair_ovf_s;

  logic                  wr_go_s;
  logic                  err_go_s;
  logic                  wr_tgt_s;
  logic                  wr_last_s;
  logic [DATA_W-1:0]     wr_d1_s;
  logic [DATA_W-1:0]     wr_d2_s;

  assign ld_ready   = (state_r == ST_GET_LO) || (state_r == ST_GET_HI);
  assign accept_s   = ld_valid & ld_ready;
  assign start_ok_s = start & can_start(state_r);
  assign inst_inc_s = (state_r == ST_WRITE) && (pair_tgt_r == TGT_INST);
  assign data_inc_s = (state_r == ST_WRITE) && (pair_tgt_r == TGT_DATA);
  assign lo_ovf_s   = (ld_target == TGT_DATA) ? data_ovf_s : inst_ovf_s;
  assign pair_ovf_s = (pair_tgt_r == TGT_DATA) ? data_ovf_s : inst_ovf_s;

  loader_addr_ctr #(.AW(DM_ADDRESS)) u_inst_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok_s),
    .inc   (inst_inc_s),
    .count (inst_cnt_s),
    .ovf   (inst_ovf_s)
  );

  loader_addr_ctr #(.AW(DM_ADDRESS)) u_data_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok_s),
    .inc   (data_inc_s),
    .count (data_cnt_s),
    .ovf   (data_ovf_s)
  );

  // Decide whether the word accepted this cycle completes a pair, and whether it writes or faults.
  always_comb begin
    wr_go_s   = 1'b0;
    err_go_s  = 1'b0;
    wr_tgt_s  = pair_tgt_r;
    wr_last_s = ld_last;
    wr_d1_s   = lo_r;
    wr_d2_s   = ld_data;
    case (state_r)
      ST_GET_LO: begin
        if (accept_s && ld_last) begin
          wr_tgt_s = ld_target;
          wr_d1_s  = ld_data;
          wr_d2_s  = {DATA_W{1'b0}};
          if (lo_ovf_s) begin
            err_go_s = 1'b1;
          end else begin
            wr_go_s = 1'b1;
          end
        end else begin
          wr_go_s = 1'b0;
        end
      end
      ST_GET_HI: begin
        if (accept_s) begin
          if ((ld_target != pair_tgt_r) || pair_ovf_s) begin
            err_go_s = 1'b1;
          end else begin
            wr_go_s = 1'b1;
          end
        end else begin
          wr_go_s = 1'b0;
        end
      end
      default: begin
        wr_go_s = 1'b0;
      end
    endcase
  end

  // Session FSM with registered strobe, buses and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r            <= ST_IDLE;
      pair_tgt_r         <= TGT_INST;
      pair_last_r        <= 1'b0;
      lo_r               <= {DATA_W{1'b0}};
      hold_cnt_r         <= {HOLD_W{1'b0}};
      enable_load_ex_mem <= 1'b0;
      InstExMemAddress   <= {DM_ADDRESS{1'b0}};
      InstExMemData1     <= {DATA_W{1'b0}};
      InstExMemData2     <= {DATA_W{1'b0}};
      DataExMemAddress   <= {DM_ADDRESS{1'b0}};
      DataExMemData1     <= {DATA_W{1'b0}};
      DataExMemData2     <= {DATA_W{1'b0}};
      core_reset         <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      enable_load_ex_mem <= 1'b0;
      if (wr_go_s) begin
        enable_load_ex_mem <= 1'b1;
        pair_last_r        <= wr_last_s;
        if (wr_tgt_s == TGT_INST) begin
          InstExMemAddress <= inst_cnt_s;
          InstExMemData1   <= wr_d1_s;
          InstExMemData2   <= wr_d2_s;
        end else begin
          DataExMemAddress <= data_cnt_s;
          DataExMemData1   <= wr_d1_s;
          DataExMemData2   <= wr_d2_s;
        end
      end
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            err        <= 1'b0;
            done       <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            state_r    <= ST_GET_LO;
          end
        end
        ST_GET_LO: begin
          if (accept_s) begin
            lo_r       <= ld_data;
            pair_tgt_r <= ld_target;
            if (err_go_s) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_ERR;
            end else if (wr_go_s) begin
              state_r <= ST_WRITE;
            end else begin
              state_r <= ST_GET_HI;
            end
          end
        end
        ST_GET_HI: begin
          if (err_go_s) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_ERR;
          end else if (wr_go_s) begin
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (pair_last_r) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            state_r    <= ST_HOLD;
          end else begin
            state_r <= ST_GET_LO;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_W'(RESET_HOLD - 1)) begin
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_r    <= ST_DONE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          core_reset <= 1'b1;
          err        <= 1'b1;
          busy       <= 1'b0;
          state_r    <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Randomised self-checking bench: a full-size loader and a 2-bit-address
// loader share one stimulus stream and are compared to a pair-level model.
module tb_riscv_mem_loader;

  localparam int DM_MAIN  = 9;
  localparam int DM_SMALL = 2;
  localparam int HOLD     = 4;

  typedef struct packed {
    logic [8:0]  ia;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [8:0]  da;
    logic [31:0] d1;
    logic [31:0] d2;
  } snap_t;

  logic clk = 1'b0;
  logic reset, start, ld_valid, ld_target, ld_last;
  logic [31:0] ld_data;

  logic m_ready, m_en, m_cr, m_busy, m_done, m_err;
  logic [8:0] m_ia, m_da;
  logic [31:0] m_i1, m_i2, m_d1, m_d2;
  logic s_ready, s_en, s_cr, s_busy, s_done, s_err;
  logic [1:0] s_ia, s_da;
  logic [31:0] s_i1, s_i2, s_d1, s_d2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_mem_loader #(.DATA_W(32), .DM_ADDRESS(DM_MAIN), .RESET_HOLD(HOLD)) u_main (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(m_ready),
    .ld_target(ld_target), .ld_data(ld_data), .ld_last(ld_last), .enable_load_ex_mem(m_en),
    .InstExMemAddress(m_ia), .InstExMemData1(m_i1), .InstExMemData2(m_i2),
    .DataExMemAddress(m_da), .DataExMemData1(m_d1), .DataExMemData2(m_d2),
    .core_reset(m_cr), .busy(m_busy), .done(m_done), .err(m_err));

  riscv_mem_loader #(.DATA_W(32), .DM_ADDRESS(DM_SMALL), .RESET_HOLD(HOLD)) u_small (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(s_ready),
    .ld_target(ld_target), .ld_data(ld_data), .ld_last(ld_last), .enable_load_ex_mem(s_en),
    .InstExMemAddress(s_ia), .InstExMemData1(s_i1), .InstExMemData2(s_i2),
    .DataExMemAddress(s_da), .DataExMemData1(s_d1), .DataExMemData2(s_d2),
    .core_reset(s_cr), .busy(s_busy), .done(s_done), .err(s_err));

  snap_t cur[2];
  logic en_v[2], cr_v[2], busy_v[2], done_v[2], err_v[2], ready_v[2];
  assign cur[0] = {m_ia, m_i1, m_i2, m_da, m_d1, m_d2};
  assign cur[1] = {7'd0, s_ia, s_i1, s_i2, 7'd0, s_da, s_d1, s_d2};
  assign en_v[0] = m_en;     assign en_v[1] = s_en;
  assign cr_v[0] = m_cr;     assign cr_v[1] = s_cr;
  assign busy_v[0] = m_busy; assign busy_v[1] = s_busy;
  assign done_v[0] = m_done; assign done_v[1] = s_done;
  assign err_v[0] = m_err;   assign err_v[1] = s_err;
  assign ready_v[0] = m_ready; assign ready_v[1] = s_ready;

  // Stimulus session and model expectations
  logic [31:0] w_data[0:15];
  logic        w_tgt[0:15];
  logic        w_last[0:15];
  int          n_words;
  snap_t       exp_bus[2];
  snap_t       exp_snap[2][0:31];
  int          exp_n[2];

  // Strobe monitor
  snap_t mon_snap[2][0:511];
  int    mon_cyc[2][0:511];
  int    mon_n[2] = '{0, 0};
  int    fall_cyc[2] = '{0, 0};
  logic  prev_cr[2] = '{1'b1, 1'b1};
  int    cyc = 0;

  // Record every write strobe and the cycle at which core_reset falls.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int id = 0; id < 2; id++) begin
      prev_cr[id] <= cr_v[id];
      if (prev_cr[id] && !cr_v[id]) fall_cyc[id] <= cyc;
      if (en_v[id] && mon_n[id] < 512) begin
        mon_snap[id][mon_n[id]] <= cur[id];
        mon_cyc[id][mon_n[id]]  <= cyc;
        mon_n[id]               <= mon_n[id] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_bus[0] = '0;
    exp_bus[1] = '0;
  endtask

  // Pair-level model: walks the word list, pairs words, counts addresses per target.
  task automatic model_run(input int id, input int aw, output int consumed, output bit e);
    int cnt[2];
    int i;
    logic t;
    logic [31:0] d1, d2;
    bit fin;
    cnt[0] = 0; cnt[1] = 0; i = 0; e = 1'b0; fin = 1'b0; consumed = 0; exp_n[id] = 0;
    while (i < n_words && !e && !fin) begin
      t = w_tgt[i]; d1 = w_data[i]; fin = w_last[i]; i++; consumed = i;
      d2 = 32'd0;
      if (!fin) begin
        if (i >= n_words) break;
        consumed = i + 1;
        if (w_tgt[i] != t) begin e = 1'b1; break; end
        d2 = w_data[i]; fin = w_last[i]; i++;
      end
      if (cnt[t] == (1 << aw)) begin e = 1'b1; break; end
      if (t == 1'b0) begin
        exp_bus[id].ia = 9'(cnt[0]); exp_bus[id].i1 = d1; exp_bus[id].i2 = d2;
      end else begin
        exp_bus[id].da = 9'(cnt[1]); exp_bus[id].d1 = d1; exp_bus[id].d2 = d2;
      end
      exp_snap[id][exp_n[id]] = exp_bus[id];
      exp_n[id]++;
      cnt[t]++;
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] d, input logic t, input logic l);
    w_data[i] = d; w_tgt[i] = t; w_last[i] = l;
  endtask

  // Present one word with random idle gaps; called and returns at a falling edge.
  task automatic send_word(input int idx);
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      ld_valid = 1'b0; ld_data = $urandom; @(negedge clk);
    end
    ld_valid = 1'b1; ld_data = w_data[idx]; ld_target = w_tgt[idx]; ld_last = w_last[idx];
    n = 0;
    while (!m_ready && n < 50) begin @(negedge clk); n++; end
    if (!m_ready) check("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic check_zero_bus(input string tag);
    check({tag, "_ia"}, m_ia, 64'd0); check({tag, "_i1"}, m_i1, 64'd0);
    check({tag, "_i2"}, m_i2, 64'd0); check({tag, "_da"}, m_da, 64'd0);
    check({tag, "_d1"}, m_d1, 64'd0); check({tag, "_d2"}, m_d2, 64'd0);
  endtask

  task automatic check_dut(input int id, input int base, input bit e, input string name);
    string p;
    snap_t g, x;
    p = $sformatf("%s_u%0d", name, id);
    check({p, "_strobes"}, 64'(mon_n[id] - base), 64'(exp_n[id]));
    for (int k = 0; k < exp_n[id]; k++) begin
      if (base + k < mon_n[id]) begin
        g = mon_snap[id][base + k]; x = exp_snap[id][k];
        check($sformatf("%s_ia%0d", p, k), g.ia, x.ia);
        check($sformatf("%s_i1_%0d", p, k), g.i1, x.i1);
        check($sformatf("%s_i2_%0d", p, k), g.i2, x.i2);
        check($sformatf("%s_da%0d", p, k), g.da, x.da);
        check($sformatf("%s_d1_%0d", p, k), g.d1, x.d1);
        check($sformatf("%s_d2_%0d", p, k), g.d2, x.d2);
      end
    end
    check({p, "_err"}, err_v[id], 64'(e));
    check({p, "_done"}, done_v[id], 64'(!e));
    check({p, "_busy"}, busy_v[id], 64'd0);
    check({p, "_core_reset"}, cr_v[id], 64'(e));
    if (e) check({p, "_ready"}, ready_v[id], 64'd0);
    if (!e && mon_n[id] > base)
      check({p, "_hold_cycles"}, 64'(fall_cyc[id] - mon_cyc[id][mon_n[id] - 1]), 64'(HOLD + 1));
  endtask

  // Start a session, stream the words the main loader will take, then compare.
  task automatic run_session(input string name, input bit mid_start);
    int c0, c1, b0, b1, w;
    bit e0, e1;
    model_run(0, DM_MAIN, c0, e0);
    model_run(1, DM_SMALL, c1, e1);
    b0 = mon_n[0]; b1 = mon_n[1];
    pulse_start();
    check({name, "_start_busy"}, m_busy, 64'd1);
    check({name, "_start_err"}, m_err, 64'd0);
    check({name, "_start_done"}, m_done, 64'd0);
    check({name, "_start_cr"}, m_cr, 64'd1);
    check({name, "_start_sbusy"}, s_busy, 64'd1);
    for (int k = 0; k < c0; k++) begin
      send_word(k);
      if (mid_start && k == 0) pulse_start();
    end
    w = 0;
    while (!((m_done | m_err) && (s_done | s_err)) && w < 40) begin @(negedge clk); w++; end
    check({name, "_finish_timeout"}, 64'(w < 40), 64'd1);
    @(negedge clk); #1;
    check_dut(0, b0, e0, name);
    check_dut(1, b1, e1, name);
    @(negedge clk);
  endtask

  task automatic gen_random();
    int i;
    logic t;
    n_words = $urandom_range(1, 14);
    i = 0;
    while (i < n_words) begin
      t = 1'($urandom_range(0, 1));
      set_word(i, $urandom, t, 1'b0); i++;
      if (i < n_words) begin
        set_word(i, $urandom, ($urandom_range(0, 9) == 0) ? ~t : t, 1'b0); i++;
      end
    end
    w_last[n_words - 1] = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_target = 1'b0; ld_last = 1'b0; ld_data = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_core_reset", m_cr, 64'd1);
    check("rst_enable", m_en, 64'd0);
    check("rst_ready", m_ready, 64'd0);
    check("rst_busy", m_busy, 64'd0);
    check("rst_done", m_done, 64'd0);
    check("rst_err", m_err, 64'd0);
    check_zero_bus("rst");
    @(negedge clk); reset = 1'b1;

    // No start: valid words are never accepted and the core stays in reset.
    ld_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ld_data = $urandom; ld_target = 1'($urandom_range(0, 1)); ld_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_ready", m_ready, 64'd0);
      check("idle_enable", m_en, 64'd0);
      check("idle_core_reset", m_cr, 64'd1);
    end
    ld_valid = 1'b0;
    check("idle_strobes", 64'(mon_n[0]), 64'd0);
    check_zero_bus("idle");

    // Two instruction words, plus an ignored start while busy.
    n_words = 2;
    set_word(0, 32'h0000_0013, 1'b0, 1'b0);
    set_word(1, 32'h0010_0093, 1'b0, 1'b1);
    run_session("inst2", 1'b1);
    check("inst2_ia", m_ia, 64'd0);
    check("inst2_i1", m_i1, 64'h0000_0013);
    check("inst2_i2", m_i2, 64'h0010_0093);

    // Three data words: second pair is padded with zero.
    n_words = 3;
    set_word(0, 32'hA, 1'b1, 1'b0);
    set_word(1, 32'hB, 1'b1, 1'b0);
    set_word(2, 32'hC, 1'b1, 1'b1);
    run_session("data3", 1'b0);
    check("data3_da", m_da, 64'd1);
    check("data3_d1", m_d1, 64'hC);
    check("data3_d2", m_d2, 64'h0);
    check("data3_inst_kept", m_i1, 64'h0000_0013);

    // Target switch inside a pair.
    n_words = 2;
    set_word(0, 32'h11, 1'b0, 1'b0);
    set_word(1, 32'h22, 1'b1, 1'b1);
    run_session("switch", 1'b0);

    // Five instruction pairs: the 2-bit loader overflows on the fifth.
    n_words = 10;
    for (int k = 0; k < 10; k++) set_word(k, 32'h100 + 32'(k), 1'b0, (k == 9));
    run_session("ovf", 1'b0);
    check("ovf_main_ia", m_ia, 64'd4);
    check("ovf_small_ia", s_ia, 64'd3);
    check("ovf_small_err", s_err, 64'd1);

    // Asynchronous reset while waiting for the second word.
    set_word(0, 32'hDEAD_0001, 1'b0, 1'b0);
    pulse_start();
    send_word(0);
    repeat ($urandom_range(1, 3)) begin ld_valid = 1'b0; @(negedge clk); end
    check("rsthi_ready_before", m_ready, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rsthi_core_reset", m_cr, 64'd1);
    check("rsthi_enable", m_en, 64'd0);
    check("rsthi_ready", m_ready, 64'd0);
    check("rsthi_busy", m_busy, 64'd0);
    check_zero_bus("rsthi");
    @(negedge clk); reset = 1'b1;
    model_reset();
    n_words = 2;
    set_word(0, 32'h5555_0000, 1'b0, 1'b0);
    set_word(1, 32'h5555_0001, 1'b0, 1'b1);
    run_session("restart", 1'b0);
    check("restart_ia", m_ia, 64'd0);

    // Asynchronous reset during the write strobe.
    set_word(0, 32'h7777_0000, 1'b1, 1'b0);
    pulse_start();
    send_word(0);
    ld_valid = 1'b1; ld_data = 32'h7777_0001; ld_target = 1'b1; ld_last = 1'b0;
    @(posedge clk);
    #2;
    check("rstwr_strobe_before", m_en, 64'd1);
    reset = 1'b0;
    #1;
    check("rstwr_enable", m_en, 64'd0);
    check("rstwr_core_reset", m_cr, 64'd1);
    check_zero_bus("rstwr");
    ld_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();

    // Randomised sessions.
    for (int r = 0; r < 12; r++) begin
      gen_random();
      run_session($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
